// File: rtl/vga_timing_pkg.sv
// Timing presets for the VGA timing generator.
// Holds the default 640x480@60 mode (module defaults) and an 800x600@60 preset,
// plus helpers to derive the total line/frame lengths from a preset.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned hActive;
        int unsigned hFp;
        int unsigned hSync;
        int unsigned hBp;
        int unsigned vActive;
        int unsigned vFp;
        int unsigned vSync;
        int unsigned vBp;
        bit          hsPol;
        bit          vsPol;
    } vgaTiming_t;

    // 640x480@60, 25.175 MHz pixel clock, negative syncs
    localparam vgaTiming_t VGA_640X480_60 = '{
        hActive: 640, hFp: 16, hSync: 96, hBp: 48,
        vActive: 480, vFp: 10, vSync: 2,  vBp: 33,
        hsPol: 1'b0, vsPol: 1'b0
    };

    // 800x600@60, 40 MHz pixel clock, positive syncs
    localparam vgaTiming_t SVGA_800X600_60 = '{
        hActive: 800, hFp: 40, hSync: 128, hBp: 88,
        vActive: 600, vFp: 1,  vSync: 4,   vBp: 23,
        hsPol: 1'b1, vsPol: 1'b1
    };

    localparam int unsigned DEF_CLK_DIV = 1;
    localparam int unsigned DEF_XW      = 11;
    localparam int unsigned DEF_YW      = 10;

    function automatic int unsigned hTotal(input vgaTiming_t t);
        return t.hActive + t.hFp + t.hSync + t.hBp;
    endfunction

    function automatic int unsigned vTotal(input vgaTiming_t t);
        return t.vActive + t.vFp + t.vSync + t.vBp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle produced by vga_timing_gen.
//   pix_tick              one-clk pulse on the cycle the other signals update
//   hsync, vsync          sync outputs at the configured active level
//   de                    display enable (visible pixel)
//   x, y                  raw column/line counts including blanking
//   line_start, frame_start  one-clk pulses at h=0 / (h=0, v=0)
interface vga_timing_gen_if #(
    parameter int unsigned XW = 11,
    parameter int unsigned YW = 10
);
    logic          pix_tick;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output pix_tick, hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        input pix_tick, hsync, vsync, de, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_pix_tick.sv
// Pixel clock-enable divider.
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   clr    synchronous clear of the divider (also masks tick)
//   tick   high on the clk where the divider sits at CLK_DIV-1
module vga_pix_tick #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int unsigned    CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] divCnt;

    // With CLK_DIV=1 the counter is stuck at 0, so clr alone gates the tick.
    assign tick = !clr && (divCnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt <= '0;
        end else if (clr || divCnt == LAST) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + CW'(1);
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator.
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   en     run enable; low holds the generator idle with syncs inactive
//   vid    timing outputs (see vga_timing_gen_if), all registered
// Outputs for counter pair (h,v) are registered on a pixel tick, after which
// the counters advance, so outputs lag the counters by one clk.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640X480_60.hActive,
    parameter int unsigned H_FP     = VGA_640X480_60.hFp,
    parameter int unsigned H_SYNC   = VGA_640X480_60.hSync,
    parameter int unsigned H_BP     = VGA_640X480_60.hBp,
    parameter int unsigned V_ACTIVE = VGA_640X480_60.vActive,
    parameter int unsigned V_FP     = VGA_640X480_60.vFp,
    parameter int unsigned V_SYNC   = VGA_640X480_60.vSync,
    parameter int unsigned V_BP     = VGA_640X480_60.vBp,
    parameter bit          HS_POL   = VGA_640X480_60.hsPol,
    parameter bit          VS_POL   = VGA_640X480_60.vsPol,
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned XW       = DEF_XW,
    parameter int unsigned YW       = DEF_YW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    vga_timing_gen_if.master vid
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > (2 ** XW)) begin : gHTotalTooWide
        $error("vga_timing_gen: H_TOTAL does not fit in XW bits");
    end
    if (V_TOTAL > (2 ** YW)) begin : gVTotalTooWide
        $error("vga_timing_gen: V_TOTAL does not fit in YW bits");
    end
    if (CLK_DIV < 1) begin : gClkDivZero
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic          clr;
    logic          tick;
    logic [XW-1:0] hCnt;
    logic [YW-1:0] vCnt;
    logic          deNext;
    logic          hsNext;
    logic          vsNext;
    logic          lineHead;
    logic          frameHead;

    assign clr = ~en;

    vga_pix_tick #(
        .CLK_DIV (CLK_DIV)
    ) uPixTick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        deNext    = (hCnt < H_ACT) && (vCnt < V_ACT);
        hsNext    = ((hCnt >= HS_BEG) && (hCnt < HS_END)) ? HS_POL : ~HS_POL;
        // vCnt only moves at h wrap, so vsync is inherently line-aligned.
        vsNext    = ((vCnt >= VS_BEG) && (vCnt < VS_END)) ? VS_POL : ~VS_POL;
        lineHead  = (hCnt == '0);
        frameHead = (hCnt == '0) && (vCnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hCnt            <= '0;
            vCnt            <= '0;
            vid.pix_tick    <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.de          <= 1'b0;
            vid.hsync       <= ~HS_POL;
            vid.vsync       <= ~VS_POL;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else if (!en) begin
            // Abort immediately: nothing of a partial frame survives.
            hCnt            <= '0;
            vCnt            <= '0;
            vid.pix_tick    <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.de          <= 1'b0;
            vid.hsync       <= ~HS_POL;
            vid.vsync       <= ~VS_POL;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.pix_tick    <= tick;
            vid.line_start  <= tick && lineHead;
            vid.frame_start <= tick && frameHead;
            if (tick) begin
                vid.x     <= hCnt;
                vid.y     <= vCnt;
                vid.de    <= deNext;
                vid.hsync <= hsNext;
                vid.vsync <= vsNext;
                if (hCnt != H_LAST) begin
                    hCnt <= hCnt + XW'(1);
                end else begin
                    hCnt <= '0;
                    vCnt <= (vCnt == V_LAST) ? '0 : vCnt + YW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small mode:
// H 8/2/3/1 (total 14), V 4/1/2/1 (total 8).
// dutA: CLK_DIV=1, pols 0; dutB: CLK_DIV=3, pols 0; dutC: CLK_DIV=1, pols 1.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rstAB = 1'b0;
    logic rstC = 1'b0;
    logic enA = 1'b1;
    logic enB = 1'b1;
    logic enC = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if vidA ();
    vga_timing_gen_if vidB ();
    vga_timing_gen_if vidC ();

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .XW(11), .YW(10)
    ) dutA (.clk(clk), .rst_n(rstAB), .en(enA), .vid(vidA));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(3), .XW(11), .YW(10)
    ) dutB (.clk(clk), .rst_n(rstAB), .en(enB), .vid(vidB));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .XW(11), .YW(10)
    ) dutC (.clk(clk), .rst_n(rstC), .en(enC), .vid(vidC));

    task automatic checkVal(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outputs k clks after reset release for a given divider/polarity.
    task automatic checkPix(input string dut, input int k, input int div, input bit pol,
                            input int obsX, input int obsY, input int obsDe, input int obsHs,
                            input int obsVs, input int obsLs, input int obsFs, input int obsPt);
        int p, h, v, eDe, eHs, eVs, eLs, eFs, ePt;
        bit tickNow;
        if (k < div) begin
            h = 0; v = 0; eDe = 0; eHs = !pol; eVs = !pol; eLs = 0; eFs = 0; ePt = 0;
        end else begin
            tickNow = (k % div) == 0;
            p   = k / div - 1;
            h   = p % 14;
            v   = (p / 14) % 8;
            eDe = (h < 8 && v < 4) ? 1 : 0;
            eHs = (h >= 10 && h < 13) ? pol : !pol;
            eVs = (v >= 5 && v < 7) ? pol : !pol;
            ePt = tickNow ? 1 : 0;
            eLs = (tickNow && h == 0) ? 1 : 0;
            eFs = (tickNow && h == 0 && v == 0) ? 1 : 0;
        end
        checkVal($sformatf("%s.x@%0d", dut, k), obsX, h);
        checkVal($sformatf("%s.y@%0d", dut, k), obsY, v);
        checkVal($sformatf("%s.de@%0d", dut, k), obsDe, eDe);
        checkVal($sformatf("%s.hsync@%0d", dut, k), obsHs, eHs);
        checkVal($sformatf("%s.vsync@%0d", dut, k), obsVs, eVs);
        checkVal($sformatf("%s.line_start@%0d", dut, k), obsLs, eLs);
        checkVal($sformatf("%s.frame_start@%0d", dut, k), obsFs, eFs);
        checkVal($sformatf("%s.pix_tick@%0d", dut, k), obsPt, ePt);
    endtask

    initial begin
        bit found;

        // Reset state, en already high
        repeat (3) @(negedge clk);
        checkVal("rstA.x", int'(vidA.x), 0);
        checkVal("rstA.y", int'(vidA.y), 0);
        checkVal("rstA.de", int'(vidA.de), 0);
        checkVal("rstA.pix_tick", int'(vidA.pix_tick), 0);
        checkVal("rstA.line_start", int'(vidA.line_start), 0);
        checkVal("rstA.frame_start", int'(vidA.frame_start), 0);
        checkVal("rstA.hsync", int'(vidA.hsync), 1);
        checkVal("rstA.vsync", int'(vidA.vsync), 1);
        checkVal("rstC.hsync", int'(vidC.hsync), 0);
        checkVal("rstC.vsync", int'(vidC.vsync), 0);

        // Release on a falling edge; k counts rising edges since release.
        rstAB = 1'b1;
        rstC  = 1'b1;
        for (int k = 1; k <= 350; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkPix("A", k, 1, 1'b0, int'(vidA.x), int'(vidA.y), int'(vidA.de),
                     int'(vidA.hsync), int'(vidA.vsync), int'(vidA.line_start),
                     int'(vidA.frame_start), int'(vidA.pix_tick));
            checkPix("B", k, 3, 1'b0, int'(vidB.x), int'(vidB.y), int'(vidB.de),
                     int'(vidB.hsync), int'(vidB.vsync), int'(vidB.line_start),
                     int'(vidB.frame_start), int'(vidB.pix_tick));
            checkPix("C", k, 1, 1'b1, int'(vidC.x), int'(vidC.y), int'(vidC.de),
                     int'(vidC.hsync), int'(vidC.vsync), int'(vidC.line_start),
                     int'(vidC.frame_start), int'(vidC.pix_tick));
        end

        // Abort dutA inside both sync pulses at (11,5)
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (vidA.x == 11 && vidA.y == 5) found = 1'b1;
        end
        checkVal("abort.reached", int'(found), 1);
        checkVal("abort.hsyncBefore", int'(vidA.hsync), 0);
        checkVal("abort.vsyncBefore", int'(vidA.vsync), 0);
        enA = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkVal($sformatf("abort.hsync#%0d", i), int'(vidA.hsync), 1);
            checkVal($sformatf("abort.vsync#%0d", i), int'(vidA.vsync), 1);
            checkVal($sformatf("abort.de#%0d", i), int'(vidA.de), 0);
            checkVal($sformatf("abort.x#%0d", i), int'(vidA.x), 0);
            checkVal($sformatf("abort.y#%0d", i), int'(vidA.y), 0);
            checkVal($sformatf("abort.pix_tick#%0d", i), int'(vidA.pix_tick), 0);
            checkVal($sformatf("abort.line_start#%0d", i), int'(vidA.line_start), 0);
        end
        enA = 1'b1;
        @(negedge clk);
        checkVal("restart.frame_start", int'(vidA.frame_start), 1);
        checkVal("restart.line_start", int'(vidA.line_start), 1);
        checkVal("restart.x", int'(vidA.x), 0);
        checkVal("restart.y", int'(vidA.y), 0);
        checkVal("restart.de", int'(vidA.de), 1);
        checkVal("restart.pix_tick", int'(vidA.pix_tick), 1);
        @(negedge clk);
        checkVal("restart.x1", int'(vidA.x), 1);
        checkVal("restart.frame_start1", int'(vidA.frame_start), 0);

        // Asynchronous reset of dutC while both positive syncs are active
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (vidC.x == 11 && vidC.y == 5) found = 1'b1;
        end
        checkVal("arst.reached", int'(found), 1);
        checkVal("arst.hsyncBefore", int'(vidC.hsync), 1);
        checkVal("arst.vsyncBefore", int'(vidC.vsync), 1);
        #2 rstC = 1'b0;
        #1;
        checkVal("arst.x", int'(vidC.x), 0);
        checkVal("arst.y", int'(vidC.y), 0);
        checkVal("arst.de", int'(vidC.de), 0);
        checkVal("arst.pix_tick", int'(vidC.pix_tick), 0);
        checkVal("arst.line_start", int'(vidC.line_start), 0);
        checkVal("arst.frame_start", int'(vidC.frame_start), 0);
        checkVal("arst.hsync", int'(vidC.hsync), 0);
        checkVal("arst.vsync", int'(vidC.vsync), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640 visible pixels; H_FP 16 h front porch; H_SYNC 96 h sync width; H_BP 48 h back porch.
REQ-002 SHALL have parameters: V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
REQ-003 SHALL have parameters: HS_POL 0 and VS_POL 0 (active sync level); CLK_DIV 1 (clocks per pixel, >=1); XW 11 and YW 10 (counter widths).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 en  in  1  run enable; low holds the generator idle.
REQ-008 pix_tick  out  1  one-clk pulse, the cycle on which all other outputs update.
REQ-009 hsync, vsync  out  1 each  sync outputs at HS_POL/VS_POL active level.
REQ-010 de  out  1  display enable (visible pixel).
REQ-011 x  out  XW, and y  out  YW  current pixel column/line counts, raw, including blanking.
REQ-012 line_start, frame_start  out  1 each  one-clk pulses.

Function
REQ-013 Derived totals SHALL be H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP; both fit XW/YW (elaboration error otherwise).
REQ-014 Internal divider SHALL count 0..CLK_DIV-1; pix_tick is high on the clk where it equals CLK_DIV-1 (every clk when CLK_DIV=1).
REQ-015 On each pix_tick, all outputs SHALL register the values for the current counter pair (h,v), and the counters SHALL then advance.
REQ-016 Counter advance: h<H_TOTAL-1 -> h+1; otherwise h=0 and v advances (v=V_TOTAL-1 -> 0, else v+1); no other wrap point.
REQ-017 Registered outputs SHALL be: x=h; y=v; de=(h<H_ACTIVE)&&(v<V_ACTIVE).
REQ-018 hsync SHALL be HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
REQ-019 vsync SHALL be VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL; vsync is line-aligned (changes only with h=0).
REQ-020 line_start SHALL be high for the pix_tick clk only when h=0; frame_start likewise only when h=0 and v=0; both are low on all other clks.
REQ-021 Outputs SHALL hold between ticks; latency from counter state to outputs is one clk.
REQ-022 en low SHALL synchronously clear the divider, h, v, x, y, de, pix_tick and pulses, and drive syncs inactive.
REQ-023 After en rises, the next tick SHALL present pixel (0,0) with frame_start=1, like the first tick after reset.
REQ-024 en falling mid-frame SHALL abort the frame on the next clk with no partial sync pulse retained.

Reset
REQ-025 While rst_n=0: divider=0, h=v=0, x=y=0, de=0, pix_tick=0, line_start=frame_start=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-026 After rst_n release with en=1, the first tick SHALL occur CLK_DIV clks later and present (0,0) with de=1, line_start=frame_start=1.

Structure
REQ-027 Package vga_timing_pkg SHALL hold the default 640x480@60 timing constants and a second preset (800x600@60); the module defaults come from it.
REQ-028 The divider SHALL be sub-module vga_pix_tick (params CLK_DIV; ports clk, rst_n, clr, tick).
REQ-029 Block size SHALL be 120-400 lines of RTL, with no combinational path from en to outputs.

Verification (small config H 8/2/3/1 -> H_TOTAL 14, V 4/1/2/1 -> V_TOTAL 8, pols 0)
REQ-030 CLK_DIV=1, en=1 after reset -> de high ticks 0-7 of each line y<4; hsync low for x=10..12; line_start every 14 clks; frame_start every 112 clks.
REQ-031 Same config -> vsync low exactly for y=5,6 (28 clks), transitions coincide with line_start; de never high for y>=4.
REQ-032 CLK_DIV=3 -> pix_tick every 3rd clk; outputs constant between ticks; frame_start period 336 clks; first tick 3 clks after reset release.
REQ-033 Deassert en at x=11,y=5 (inside both syncs) -> next clk hsync=vsync=1, de=0, x=y=0; re-assert -> next tick frame_start=1 at (0,0).
REQ-034 HS_POL=1, VS_POL=1 -> syncs idle low in reset and high only in the REQ-018/019 windows; assert rst_n low mid-line -> all outputs at reset values asynchronously.
